pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 92 +++++++++
 tb/tb_pipe_stage_buf.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: small FIFO decoupling the fetch stage from decode.
// Carries {pc, inst} pairs, one-cycle latency, full-rate push+pop when
// partially occupied. Outputs read as a bubble (all zero) when empty.
// in_ready depends on registered occupancy only, so there is no
// combinational path from out_ready back to in_ready.

module pipe_stage_buf #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic [$clog2(DEPTH+1)-1:0] out_count
);

   // A single-entry buffer still needs a 1-bit pointer; it simply never moves.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int MEM_N = 1 << PTR_W;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [PC_W-1:0]   r_pc_mem   [MEM_N];
   logic [INST_W-1:0] r_inst_mem [MEM_N];

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;
   logic w_empty;
   logic w_full;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);

   // Flush suppresses both handshakes so it wins over any same-cycle transfer.
   assign w_push = in_valid && !w_full && !flush;
   assign w_pop  = !w_empty && out_ready && !flush;

   // Pointer and occupancy bookkeeping; flush and reset both empty the buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents of empty slots are don't-care, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= in_pc;
         r_inst_mem[r_wr_ptr] <= in_inst;
      end
   end

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign out_count = r_count;
   assign out_pc    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
   assign out_inst  = w_empty ? '0 : r_inst_mem[r_rd_ptr];

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (DEPTH 2, 4, 1) driven with
// directed vectors. Expected {pc, inst} entries are queued when issued and
// popped by per-instance monitors whenever the DUT completes an output
// handshake; occupancy/ready/bubble values are checked inline.

module tb_pipe_stage_buf;

   logic clk;
   logic reset;
   logic flush;

   int checks;
   int errors;

   // instance A: DEPTH=2
   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [31:0] in_pc_a, in_inst_a, out_pc_a, out_inst_a;
   logic [1:0]  out_count_a;
   // instance B: DEPTH=4
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [31:0] in_pc_b, in_inst_b, out_pc_b, out_inst_b;
   logic [2:0]  out_count_b;
   // instance C: DEPTH=1
   logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c;
   logic [31:0] in_pc_c, in_inst_c, out_pc_c, out_inst_c;
   logic [0:0]  out_count_c;

   logic [63:0] q_a[$];
   logic [63:0] q_b[$];
   logic [63:0] q_c[$];

   pipe_stage_buf #(.PC_W(32), .INST_W(32), .DEPTH(2)) u_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_pc(in_pc_a), .in_inst(in_inst_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pc(out_pc_a),
      .out_inst(out_inst_a), .out_count(out_count_a));

   pipe_stage_buf #(.PC_W(32), .INST_W(32), .DEPTH(4)) u_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pc(in_pc_b), .in_inst(in_inst_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_pc(out_pc_b),
      .out_inst(out_inst_b), .out_count(out_count_b));

   pipe_stage_buf #(.PC_W(32), .INST_W(32), .DEPTH(1)) u_c (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid_c), .in_ready(in_ready_c), .in_pc(in_pc_c), .in_inst(in_inst_c),
      .out_valid(out_valid_c), .out_ready(out_ready_c), .out_pc(out_pc_c),
      .out_inst(out_inst_c), .out_count(out_count_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Monitors: a completed output handshake must match the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid_a && out_ready_a) begin
         if (q_a.size() == 0) chk("a_unexpected_out", {out_pc_a, out_inst_a}, 64'hDEAD);
         else chk("a_out_entry", {out_pc_a, out_inst_a}, q_a.pop_front());
      end
      if (!reset && !flush && out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) chk("b_unexpected_out", {out_pc_b, out_inst_b}, 64'hDEAD);
         else chk("b_out_entry", {out_pc_b, out_inst_b}, q_b.pop_front());
      end
      if (!reset && !flush && out_valid_c && out_ready_c) begin
         if (q_c.size() == 0) chk("c_unexpected_out", {out_pc_c, out_inst_c}, 64'hDEAD);
         else chk("c_out_entry", {out_pc_c, out_inst_c}, q_c.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      flush = 1'b0;
      in_valid_a = 0; out_ready_a = 0; in_pc_a = '0; in_inst_a = '0;
      in_valid_b = 0; out_ready_b = 0; in_pc_b = '0; in_inst_b = '0;
      in_valid_c = 0; out_ready_c = 0; in_pc_c = '0; in_inst_c = '0;

      // reset state, before any clock edge
      #2;
      chk("rst_a_count",    64'(out_count_a), 64'd0);
      chk("rst_a_valid",    64'(out_valid_a), 64'd0);
      chk("rst_a_in_ready", 64'(in_ready_a),  64'd1);
      chk("rst_a_pc",       64'(out_pc_a),    64'd0);
      chk("rst_b_count",    64'(out_count_b), 64'd0);
      chk("rst_c_in_ready", 64'(in_ready_c),  64'd1);

      // fill and drain on A, first push right after reset release
      tick();
      reset = 1'b0;
      in_valid_a = 1; in_pc_a = 32'h100; in_inst_a = 32'hAAAA0001;
      q_a.push_back({32'h100, 32'hAAAA0001});
      mid();
      chk("fill_a_count0",    64'(out_count_a), 64'd0);
      chk("fill_a_in_ready0", 64'(in_ready_a),  64'd1);
      tick();
      in_pc_a = 32'h104; in_inst_a = 32'hAAAA0002;
      q_a.push_back({32'h104, 32'hAAAA0002});
      mid();
      chk("fill_a_count1",  64'(out_count_a), 64'd1);
      chk("fill_a_latency", 64'(out_pc_a),    64'h100);
      tick();
      in_pc_a = 32'h108; in_inst_a = 32'hAAAA0003;
      mid();
      chk("fill_a_count2", 64'(out_count_a), 64'd2);
      chk("fill_a_full",   64'(in_ready_a),  64'd0);
      tick();
      out_ready_a = 1;
      mid();
      chk("fill_a_third_ignored", 64'(out_count_a), 64'd2);
      tick();
      in_valid_a = 0;
      mid();
      chk("fill_a_no_overflow", 64'(out_count_a), 64'd1);
      tick();
      mid();
      chk("drain_a_count", 64'(out_count_a), 64'd0);
      chk("drain_a_valid", 64'(out_valid_a), 64'd0);
      chk("drain_a_bubble", {out_pc_a, out_inst_a}, 64'd0);
      tick();
      mid();
      chk("empty_a_pop_ignored", 64'(out_count_a), 64'd0);

      // throughput: continuous push and pop on A
      for (int k = 0; k < 8; k++) begin
         tick();
         in_valid_a = 1; in_pc_a = 32'(4 * k); in_inst_a = 32'hBB000000 + 32'(k);
         q_a.push_back({32'(4 * k), 32'hBB000000 + 32'(k)});
         mid();
         chk("thru_a_count", 64'(out_count_a), (k == 0) ? 64'd0 : 64'd1);
      end
      tick();
      in_valid_a = 0;
      mid();
      chk("thru_a_tail_count", 64'(out_count_a), 64'd1);
      tick();
      mid();
      chk("thru_a_drained", 64'(out_count_a), 64'd0);

      // flush priority over push and pop
      tick();
      out_ready_a = 0; in_valid_a = 1; in_pc_a = 32'h300; in_inst_a = 32'hCC000001;
      q_a.push_back({32'h300, 32'hCC000001});
      tick();
      in_valid_a = 0;
      mid();
      chk("flush_a_pre_count", 64'(out_count_a), 64'd1);
      tick();
      flush = 1; in_valid_a = 1; in_pc_a = 32'h304; in_inst_a = 32'hCC000002; out_ready_a = 1;
      q_a.delete();
      tick();
      flush = 0; in_valid_a = 0;
      mid();
      chk("flush_a_count", 64'(out_count_a), 64'd0);
      chk("flush_a_valid", 64'(out_valid_a), 64'd0);
      chk("flush_a_inst",  64'(out_inst_a),  64'd0);
      tick();
      mid();
      chk("flush_a_not_stored", 64'(out_count_a), 64'd0);

      // reset asserted between edges with two entries held
      tick();
      out_ready_a = 0; in_valid_a = 1; in_pc_a = 32'h400; in_inst_a = 32'hAB000001;
      q_a.push_back({32'h400, 32'hAB000001});
      tick();
      in_pc_a = 32'h404; in_inst_a = 32'hAB000002;
      q_a.push_back({32'h404, 32'hAB000002});
      tick();
      in_valid_a = 0;
      mid();
      chk("rstmid_a_pre_count", 64'(out_count_a), 64'd2);
      @(posedge clk);
      #3;
      reset = 1;
      q_a.delete();
      #1;
      chk("rstmid_a_valid",    64'(out_valid_a), 64'd0);
      chk("rstmid_a_count",    64'(out_count_a), 64'd0);
      chk("rstmid_a_in_ready", 64'(in_ready_a),  64'd1);
      chk("rstmid_a_bubble",   {out_pc_a, out_inst_a}, 64'd0);
      tick();
      reset = 0;
      mid();
      chk("rstmid_a_post_count", 64'(out_count_a), 64'd0);

      // wrap-around on B: hold 3 entries, then 10 push/pop pairs, then drain
      for (int k = 0; k < 13; k++) begin
         tick();
         in_valid_b = 1; in_pc_b = 32'h500 + 32'(4 * k); in_inst_b = 32'hDD000000 + 32'(k);
         q_b.push_back({32'h500 + 32'(4 * k), 32'hDD000000 + 32'(k)});
         if (k >= 3) begin
            out_ready_b = 1;
            mid();
            chk("wrap_b_count", 64'(out_count_b), 64'd3);
         end
      end
      tick();
      in_valid_b = 0;
      for (int j = 3; j >= 0; j--) begin
         mid();
         chk("wrap_b_drain_count", 64'(out_count_b), 64'(j));
         tick();
      end
      out_ready_b = 0;

      // DEPTH=1 stall behaviour on C
      in_valid_c = 1; in_pc_c = 32'h200; in_inst_c = 32'hEE000001;
      q_c.push_back({32'h200, 32'hEE000001});
      mid();
      chk("d1_c_in_ready_empty", 64'(in_ready_c), 64'd1);
      tick();
      in_pc_c = 32'h2FF; in_inst_c = 32'hEE0000FF;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("d1_c_hold_pc",  64'(out_pc_c),   64'h200);
         chk("d1_c_in_ready", 64'(in_ready_c), 64'd0);
         tick();
      end
      in_valid_c = 0; out_ready_c = 1;
      mid();
      tick();
      out_ready_c = 0;
      mid();
      chk("d1_c_ready_after_pop", 64'(in_ready_c),  64'd1);
      chk("d1_c_count_after_pop", 64'(out_count_c), 64'd0);

      tick();
      chk("end_q_a_empty", 64'(q_a.size()), 64'd0);
      chk("end_q_b_empty", 64'(q_b.size()), 64'd0);
      chk("end_q_c_empty", 64'(q_c.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
